irq_ctrl: RTL
=============

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0F00: byte base of the 32-byte register window.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 mem_wr  input  1  store strobe from the memory stage.
REQ-005 mem_read  input  1  load strobe from the memory stage.
REQ-006 addr  input  32  byte address (ALU result).
REQ-007 data_wr  input  32  store data.
REQ-008 rdata  output  32  load data; combinational.
REQ-009 ext_irq  input  3  external sources, synchronous to clk.
REQ-010 epc_taken  input  1  CSR block has trapped on the asserted interrupt.
REQ-011 is_mret  input  1  handler return executed.
REQ-012 interrupt  output  4  registered, one-hot or zero; bit0 timer, bits1-3 ext_irq[0..2].

Function
REQ-013 Register map at BASE_ADDR, word offsets: 0x00 mtime RW, 0x04 mtimecmp RW, 0x08 enable[3:0] RW, 0x0C pending[3:0] read / write-1-to-clear, 0x10 status {state[1:0] in bits 5:4, active_id[1:0] in bits 1:0} RO.
REQ-014 Selection: addr[31:5]==BASE_ADDR[31:5], word index addr[4:2]; addr[1:0] ignored; unmapped offsets read 0, writes ignored.
REQ-015 rdata = selected register when mem_read and address selected, else 32'h0; unused bits read 0.
REQ-016 mtime increments by 1 every cycle, wraps 32'hFFFF_FFFF -> 0; a store to mtime loads data_wr instead of incrementing that cycle.
REQ-017 pending[0] sets on the edge where mtime==mtimecmp (equality, not >=).
REQ-018 ext_irq registered once (ext_q); pending[i+1] sets on the edge where ext_irq[i] & ~ext_q[i].
REQ-019 Set has priority over write-1-to-clear on the same bit in the same cycle.
REQ-020 FSM states IDLE, ASSERT, SERVICE.
REQ-021 IDLE: if (pending & enable)!=0, latch active_id = lowest-index set bit, go ASSERT, interrupt = one-hot(active_id) from the next cycle.
REQ-022 ASSERT: hold interrupt; on epc_taken clear pending[active_id], drive interrupt=0, go SERVICE.
REQ-023 SERVICE: interrupt=0; on is_mret go IDLE; new pendings accumulate but are not asserted (no nesting).
REQ-024 epc_taken outside ASSERT and is_mret outside SERVICE are ignored.
REQ-025 Clearing enable[active_id] or pending[active_id] while in ASSERT withdraws the request: interrupt=0, go IDLE next cycle.
REQ-026 Latency: ext_irq rising before edge k -> pending visible after k -> interrupt asserted after k+1.
REQ-027 Pending and enable bits persist across state changes; a disabled source pends and is asserted once enabled.

Reset
REQ-028 On rst: mtime=0, mtimecmp=32'hFFFF_FFFF, enable=0, pending=0, ext_q=0, active_id=0, state=IDLE, interrupt=0.
REQ-029 rst mid-ASSERT or mid-SERVICE abandons the request; no interrupt bit is asserted in the cycle after rst.

Configuration
REQ-030 IRQ_TIMER_EN defined: mtime/mtimecmp and pending[0] behave as specified.
REQ-031 IRQ_TIMER_EN undefined: no timer logic; offsets 0x00/0x04 read 0 and ignore writes; pending[0] and interrupt[0] constant 0; enable[0] reads 0.

Verification
REQ-032 Reset, enable=4'b0010, pulse ext_irq[0] 1 cycle -> pending=4'b0010 after 1 edge, interrupt=4'b0010 after 2, held until epc_taken, then 0, status state=SERVICE.
REQ-033 Write mtime=10, mtimecmp=15, enable=1 -> pending[0] sets on the edge mtime==15, interrupt=4'b0001 next cycle; epc_taken then is_mret -> IDLE, pending=0.
REQ-034 ext_irq[2:0] rise together, enable=4'hE -> interrupt=4'b0010 first; after epc_taken and is_mret -> 4'b0100, then 4'b1000.
REQ-035 Write pending=4'b0100 (W1C) in the same cycle ext_irq[1] edge sets it -> pending[2] remains 1.
REQ-036 rst asserted while interrupt=4'b1000 -> interrupt=0, pending=0, state=IDLE; loads from BASE_ADDR+0x08 return 0.

Source files
------------

// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller with an optional machine timer.
//
// It gathers three external interrupt sources and one timer source into a
// pending register, masks them with an enable register, and presents at most
// one request at a time to the CSR/trap logic as a registered one-hot vector.
// Once the core traps (epc_taken), the controller waits for the handler to
// return (is_mret) before it arbitrates again, so interrupts never nest.
//
// Build option: define IRQ_TIMER_EN to include mtime/mtimecmp and timer
// source 0. Without it, offsets 0x00/0x04 read 0, source 0 never pends, and
// enable[0] reads 0.
//
// Register window (BASE_ADDR, 32 bytes, word index addr[4:2]):
//   0x00 mtime     RW   free-running counter, +1 per cycle
//   0x04 mtimecmp  RW   timer compare (equality match)
//   0x08 enable    RW   [3:0]
//   0x0C pending   R/W1C [3:0]
//   0x10 status    RO   [5:4] state, [1:0] active_id
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   mem_wr        store strobe from the memory stage
//   mem_read      load strobe from the memory stage
//   addr          byte address
//   data_wr       store data
//   rdata         load data (combinational, 0 when not a mapped load)
//   ext_irq[2:0]  external sources, synchronous to clk, edge-detected
//   epc_taken     core has trapped on the presented interrupt
//   is_mret       handler return
//   interrupt     registered one-hot request: bit0 timer, bits1-3 ext_irq[0..2]
//
// State | meaning
// IDLE    | no request outstanding, arbitrate among pending & enabled
// ASSERT  | interrupt driven for active_id, waiting for epc_taken
// SERVICE | handler running, waiting for is_mret

module irq_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0F00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_wr,
  input  logic        mem_read,
  input  logic [31:0] addr,
  input  logic [31:0] data_wr,
  output logic [31:0] rdata,
  input  logic [2:0]  ext_irq,
  input  logic        epc_taken,
  input  logic        is_mret,
  output logic [3:0]  interrupt
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ASSERT  = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  localparam logic [2:0] IDX_MTIME    = 3'd0;
  localparam logic [2:0] IDX_MTIMECMP = 3'd1;
  localparam logic [2:0] IDX_ENABLE   = 3'd2;
  localparam logic [2:0] IDX_PENDING  = 3'd3;
  localparam logic [2:0] IDX_STATUS   = 3'd4;

  logic        sel;
  logic [2:0]  idx;
  logic        wr_sel;

  logic [1:0]  state_q, state_d;
  logic [1:0]  active_id_q, active_id_d;
  logic [3:0]  interrupt_q, interrupt_d;
  logic [3:0]  enable_q, enable_d;
  logic [3:0]  pending_q, pending_d;
  logic [2:0]  ext_q;

  logic [3:0]  en_mask;
  logic        timer_hit;
  logic [31:0] rd_mtime;
  logic [31:0] rd_mtimecmp;

  logic [3:0]  set_vec;
  logic [3:0]  clr_w1c;
  logic [3:0]  clr_epc;
  logic [3:0]  pend_no_epc;
  logic [3:0]  ready;
  logic [1:0]  lowest_id;

  assign sel    = (addr[31:5] == BASE_ADDR[31:5]);
  assign idx    = addr[4:2];
  assign wr_sel = mem_wr & sel;

`ifdef IRQ_TIMER_EN
  logic [31:0] mtime_q, mtime_d;
  logic [31:0] mtimecmp_q, mtimecmp_d;
  logic        unused_addr;

  assign unused_addr = ^addr[1:0];
  assign en_mask     = 4'hF;

  // A store to mtime replaces that cycle's increment.
  always_comb begin
    mtime_d    = mtime_q + 32'd1;
    mtimecmp_d = mtimecmp_q;
    if (wr_sel && (idx == IDX_MTIME))    mtime_d    = data_wr;
    if (wr_sel && (idx == IDX_MTIMECMP)) mtimecmp_d = data_wr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q    <= 32'h0;
      mtimecmp_q <= 32'hFFFF_FFFF;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
    end
  end

  assign timer_hit   = (mtime_q == mtimecmp_q);
  assign rd_mtime    = mtime_q;
  assign rd_mtimecmp = mtimecmp_q;
`else
  logic unused_bits;

  assign unused_bits = ^{addr[1:0], data_wr[31:4]};
  assign en_mask     = 4'hE;
  assign timer_hit   = 1'b0;
  assign rd_mtime    = 32'h0;
  assign rd_mtimecmp = 32'h0;
`endif

  assign set_vec     = {ext_irq & ~ext_q, timer_hit};
  assign clr_w1c     = (wr_sel && (idx == IDX_PENDING)) ? data_wr[3:0] : 4'h0;
  assign enable_d    = (wr_sel && (idx == IDX_ENABLE)) ? (data_wr[3:0] & en_mask) : enable_q;
  // Pending as it will be after this edge, ignoring the trap acknowledge;
  // used to detect a request withdrawn by software while in ASSERT.
  assign pend_no_epc = (pending_q & ~clr_w1c) | set_vec;
  // New events win over any clear landing in the same cycle.
  assign pending_d   = (pending_q & ~(clr_w1c | clr_epc)) | set_vec;
  assign ready       = pending_q & enable_q;

  always_comb begin
    lowest_id = 2'd0;
    if (ready[0])      lowest_id = 2'd0;
    else if (ready[1]) lowest_id = 2'd1;
    else if (ready[2]) lowest_id = 2'd2;
    else if (ready[3]) lowest_id = 2'd3;
  end

  always_comb begin
    state_d     = state_q;
    active_id_d = active_id_q;
    interrupt_d = interrupt_q;
    clr_epc     = 4'h0;
    case (state_q)
      ST_IDLE: begin
        interrupt_d = 4'h0;
        if (|ready) begin
          active_id_d = lowest_id;
          interrupt_d = 4'b0001 << lowest_id;
          state_d     = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        if (epc_taken) begin
          clr_epc     = 4'b0001 << active_id_q;
          interrupt_d = 4'h0;
          state_d     = ST_SERVICE;
        end else if (!(enable_d[active_id_q] && pend_no_epc[active_id_q])) begin
          interrupt_d = 4'h0;
          state_d     = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        interrupt_d = 4'h0;
        if (is_mret) state_d = ST_IDLE;
      end
      default: begin
        interrupt_d = 4'h0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      active_id_q <= 2'd0;
      interrupt_q <= 4'h0;
      enable_q    <= 4'h0;
      pending_q   <= 4'h0;
      ext_q       <= 3'h0;
    end else begin
      state_q     <= state_d;
      active_id_q <= active_id_d;
      interrupt_q <= interrupt_d;
      enable_q    <= enable_d;
      pending_q   <= pending_d;
      ext_q       <= ext_irq;
    end
  end

  always_comb begin
    rdata = 32'h0;
    if (mem_read && sel) begin
      case (idx)
        IDX_MTIME:    rdata = rd_mtime;
        IDX_MTIMECMP: rdata = rd_mtimecmp;
        IDX_ENABLE:   rdata = {28'h0, enable_q};
        IDX_PENDING:  rdata = {28'h0, pending_q};
        IDX_STATUS:   rdata = {26'h0, state_q, 2'b00, active_id_q};
        default:      rdata = 32'h0;
      endcase
    end
  end

  assign interrupt = interrupt_q;

endmodule
